pri_enc16_seq: RTL

PRI_ENC16_SEQ -- requirements
Module: pri_enc16_seq

---
 rtl/pri_enc16_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/pri_enc16_seq.sv
// Sequential priority encoder: drains each accepted request vector one set bit per beat, highest index first.
// Optional macro PENC_ZERO_EMIT_EN: an all-zero vector produces a single flagged beat on out_zero.
module pri_enc16_seq #(
   parameter int N_IN  = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_IN-1:0]  in_vec,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
`ifdef PENC_ZERO_EMIT_EN
   output logic             out_zero,
`endif
   output logic [IDX_W:0]   pend_cnt
);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t          state;
   logic [N_IN-1:0] pend;
   logic [N_IN-1:0] pend_nx;

   function automatic logic [IDX_W-1:0] top_bit(input logic [N_IN-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_IN; i++)
         if (v[i]) idx = IDX_W'(i);
      return idx;
   endfunction

   function automatic logic [IDX_W:0] pop_cnt(input logic [N_IN-1:0] v);
      logic [IDX_W:0] c;
      c = '0;
      for (int i = 0; i < N_IN; i++)
         c = c + {{IDX_W{1'b0}}, v[i]};
      return c;
   endfunction

   // Pending vector after the currently presented bit is consumed.
   always_comb begin
      pend_nx = pend;
      pend_nx[out_idx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         pend_cnt  <= '0;
`ifdef PENC_ZERO_EMIT_EN
         out_zero  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  pend <= in_vec;
                  if (|in_vec) begin
                     state     <= EMIT;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_idx   <= top_bit(in_vec);
                     pend_cnt  <= pop_cnt(in_vec);
                     out_last  <= (pop_cnt(in_vec) == (IDX_W+1)'(1));
                  end
`ifdef PENC_ZERO_EMIT_EN
                  else begin
                     state     <= EMIT;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_idx   <= '0;
                     pend_cnt  <= '0;
                     out_last  <= 1'b1;
                     out_zero  <= 1'b1;
                  end
`endif
               end
            end
            EMIT: begin
               if (out_ready) begin
                  pend <= pend_nx;
                  if (out_last) begin
                     state     <= IDLE;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                     out_idx   <= '0;
                     pend_cnt  <= '0;
                     out_last  <= 1'b0;
`ifdef PENC_ZERO_EMIT_EN
                     out_zero  <= 1'b0;
`endif
                  end else begin
                     out_idx  <= top_bit(pend_nx);
                     pend_cnt <= pend_cnt - (IDX_W+1)'(1);
                     out_last <= (pend_cnt == (IDX_W+1)'(2));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
